// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with NZCV status register and saturating squash counter.
// Optional macro SR_BYPASS_EN forwards committing ALU flags combinationally onto sr_nzcv.
module id_exe_stage_reg #(
  parameter int SQ_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                hazard,
  input  logic                cond_pass,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_val_rn,
  input  logic [31:0]         id_val_rm,
  input  logic [11:0]         id_shift_op,
  input  logic                id_imm,
  input  logic [23:0]         id_simm24,
  input  logic [3:0]          id_dest,
  input  logic [3:0]          id_src1,
  input  logic [3:0]          id_src2,
  input  logic [3:0]          id_exe_cmd,
  input  logic                id_mem_r,
  input  logic                id_mem_w,
  input  logic                id_wb_en,
  input  logic                id_s,
  input  logic                id_b,
  input  logic [3:0]          alu_nzcv,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [31:0]         ex_val_rn,
  output logic [31:0]         ex_val_rm,
  output logic [11:0]         ex_shift_op,
  output logic                ex_imm,
  output logic [23:0]         ex_simm24,
  output logic [3:0]          ex_dest,
  output logic [3:0]          ex_src1,
  output logic [3:0]          ex_src2,
  output logic [3:0]          ex_exe_cmd,
  output logic                ex_mem_r,
  output logic                ex_mem_w,
  output logic                ex_wb_en,
  output logic                ex_s,
  output logic                ex_b,
  output logic [3:0]          sr_nzcv,
  output logic [SQ_CNT_W-1:0] squash_cnt
);

  logic                validQ, validD;
  logic [31:0]         pcQ, pcD, valRnQ, valRnD, valRmQ, valRmD;
  logic [11:0]         shiftOpQ, shiftOpD;
  logic                immQ, immD;
  logic [23:0]         simm24Q, simm24D;
  logic [3:0]          destQ, destD, src1Q, src1D, src2Q, src2D, exeCmdQ, exeCmdD;
  logic                memRQ, memRD, memWQ, memWD, wbEnQ, wbEnD, sQ, sD, bQ, bD;
  logic [3:0]          srQ, srD;
  logic [SQ_CNT_W-1:0] cntQ, cntD;
  logic                bubble, commit, squashEvt;

  assign bubble    = hazard | ~cond_pass | ~id_valid;
  assign commit    = validQ & sQ & ~freeze;
  assign squashEvt = ~flush & ~freeze & id_valid & ~hazard & ~cond_pass;

  always_comb begin
    validD   = validQ;
    pcD      = pcQ;
    valRnD   = valRnQ;
    valRmD   = valRmQ;
    shiftOpD = shiftOpQ;
    immD     = immQ;
    simm24D  = simm24Q;
    destD    = destQ;
    src1D    = src1Q;
    src2D    = src2Q;
    exeCmdD  = exeCmdQ;
    memRD    = memRQ;
    memWD    = memWQ;
    wbEnD    = wbEnQ;
    sD       = sQ;
    bD       = bQ;
    if (flush) begin
      validD   = 1'b0;
      pcD      = '0;
      valRnD   = '0;
      valRmD   = '0;
      shiftOpD = '0;
      immD     = 1'b0;
      simm24D  = '0;
      destD    = '0;
      src1D    = '0;
      src2D    = '0;
      exeCmdD  = '0;
      memRD    = 1'b0;
      memWD    = 1'b0;
      wbEnD    = 1'b0;
      sD       = 1'b0;
      bD       = 1'b0;
    end else if (!freeze) begin
      // Data fields always follow ID; a bubble only kills the command and controls.
      pcD      = id_pc;
      valRnD   = id_val_rn;
      valRmD   = id_val_rm;
      shiftOpD = id_shift_op;
      immD     = id_imm;
      simm24D  = id_simm24;
      destD    = id_dest;
      src1D    = id_src1;
      src2D    = id_src2;
      validD   = ~bubble;
      exeCmdD  = bubble ? 4'h0 : id_exe_cmd;
      memRD    = ~bubble & id_mem_r;
      memWD    = ~bubble & id_mem_w;
      wbEnD    = ~bubble & id_wb_en;
      sD       = ~bubble & id_s;
      bD       = ~bubble & id_b;
    end
    // Flush does not block the commit: the branch in EXE still retires.
    srD  = commit ? alu_nzcv : srQ;
    cntD = (squashEvt && (cntQ != '1)) ? cntQ + 1'b1 : cntQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ   <= 1'b0;
      pcQ      <= '0;
      valRnQ   <= '0;
      valRmQ   <= '0;
      shiftOpQ <= '0;
      immQ     <= 1'b0;
      simm24Q  <= '0;
      destQ    <= '0;
      src1Q    <= '0;
      src2Q    <= '0;
      exeCmdQ  <= '0;
      memRQ    <= 1'b0;
      memWQ    <= 1'b0;
      wbEnQ    <= 1'b0;
      sQ       <= 1'b0;
      bQ       <= 1'b0;
      srQ      <= '0;
      cntQ     <= '0;
    end else begin
      validQ   <= validD;
      pcQ      <= pcD;
      valRnQ   <= valRnD;
      valRmQ   <= valRmD;
      shiftOpQ <= shiftOpD;
      immQ     <= immD;
      simm24Q  <= simm24D;
      destQ    <= destD;
      src1Q    <= src1D;
      src2Q    <= src2D;
      exeCmdQ  <= exeCmdD;
      memRQ    <= memRD;
      memWQ    <= memWD;
      wbEnQ    <= wbEnD;
      sQ       <= sD;
      bQ       <= bD;
      srQ      <= srD;
      cntQ     <= cntD;
    end
  end

  assign ex_valid    = validQ;
  assign ex_pc       = pcQ;
  assign ex_val_rn   = valRnQ;
  assign ex_val_rm   = valRmQ;
  assign ex_shift_op = shiftOpQ;
  assign ex_imm      = immQ;
  assign ex_simm24   = simm24Q;
  assign ex_dest     = destQ;
  assign ex_src1     = src1Q;
  assign ex_src2     = src2Q;
  assign ex_exe_cmd  = exeCmdQ;
  assign ex_mem_r    = memRQ;
  assign ex_mem_w    = memWQ;
  assign ex_wb_en    = wbEnQ;
  assign ex_s        = sQ;
  assign ex_b        = bQ;
  assign squash_cnt  = cntQ;

`ifdef SR_BYPASS_EN
  // Same-cycle forwarding lets the next ID instruction use fresh flags without a stall.
  assign sr_nzcv = commit ? alu_nzcv : srQ;
`else
  assign sr_nzcv = srQ;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg (default SQ_CNT_W = 16).
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard, cond_pass, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0] id_shift_op;
  logic        id_imm;
  logic [23:0] id_simm24;
  logic [3:0]  id_dest, id_src1, id_src2, id_exe_cmd;
  logic        id_mem_r, id_mem_w, id_wb_en, id_s, id_b;
  logic [3:0]  alu_nzcv;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_op;
  logic        ex_imm;
  logic [23:0] ex_simm24;
  logic [3:0]  ex_dest, ex_src1, ex_src2, ex_exe_cmd;
  logic        ex_mem_r, ex_mem_w, ex_wb_en, ex_s, ex_b;
  logic [3:0]  sr_nzcv;
  logic [15:0] squash_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .cond_pass(cond_pass), .id_valid(id_valid), .id_pc(id_pc),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_shift_op(id_shift_op),
    .id_imm(id_imm), .id_simm24(id_simm24), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .id_exe_cmd(id_exe_cmd),
    .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_wb_en(id_wb_en),
    .id_s(id_s), .id_b(id_b), .alu_nzcv(alu_nzcv),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
    .ex_val_rm(ex_val_rm), .ex_shift_op(ex_shift_op), .ex_imm(ex_imm),
    .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_exe_cmd(ex_exe_cmd), .ex_mem_r(ex_mem_r),
    .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en), .ex_s(ex_s), .ex_b(ex_b),
    .sr_nzcv(sr_nzcv), .squash_cnt(squash_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic liveInstr(input logic [31:0] pc, input logic [3:0] dest, input logic s);
    id_valid = 1'b1; cond_pass = 1'b1; hazard = 1'b0;
    id_pc = pc; id_dest = dest; id_s = s;
    id_exe_cmd = 4'h5; id_wb_en = 1'b1; id_mem_r = 1'b0; id_mem_w = 1'b0; id_b = 1'b0;
  endtask

  initial begin
    // Reset with every input non-zero
    rst = 1'b1; freeze = 1'b1; flush = 1'b1; hazard = 1'b1; cond_pass = 1'b1; id_valid = 1'b1;
    id_pc = 32'hFFFF_FFF0; id_val_rn = 32'h1234_5678; id_val_rm = 32'h8765_4321;
    id_shift_op = 12'hABC; id_imm = 1'b1; id_simm24 = 24'hFFFFFF;
    id_dest = 4'hF; id_src1 = 4'hE; id_src2 = 4'hD; id_exe_cmd = 4'hC;
    id_mem_r = 1'b1; id_mem_w = 1'b1; id_wb_en = 1'b1; id_s = 1'b1; id_b = 1'b1;
    alu_nzcv = 4'hF;
    step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rn", ex_val_rn, 0);
    chk("rst_simm", ex_simm24, 0);
    chk("rst_ctrl", {ex_mem_r, ex_mem_w, ex_wb_en, ex_s, ex_b}, 0);
    chk("rst_sr", sr_nzcv, 0);
    chk("rst_cnt", squash_cnt, 0);

    // Normal load
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; alu_nzcv = 4'b0110;
    liveInstr(32'h10, 4'h3, 1'b0);
    id_val_rn = 32'hAAAA_0001;
    step();
    chk("load_valid", ex_valid, 1);
    chk("load_wb", ex_wb_en, 1);
    chk("load_dest", ex_dest, 3);
    chk("load_pc", ex_pc, 32'h10);
    chk("load_cmd", ex_exe_cmd, 5);
    chk("load_rn", ex_val_rn, 32'hAAAA_0001);
    chk("load_sr", sr_nzcv, 0);

    // Condition squash: data loads, controls die, counter bumps
    cond_pass = 1'b0; id_mem_w = 1'b1; id_pc = 32'h14;
    step();
    chk("sq_valid", ex_valid, 0);
    chk("sq_memw", ex_mem_w, 0);
    chk("sq_cmd", ex_exe_cmd, 0);
    chk("sq_pc", ex_pc, 32'h14);
    chk("sq_cnt", squash_cnt, 1);

    // Hazard bubble is not counted
    hazard = 1'b1; id_pc = 32'h18;
    step();
    chk("hz_valid", ex_valid, 0);
    chk("hz_cnt", squash_cnt, 1);

    // Freeze hold over three cycles, inputs would otherwise squash
    liveInstr(32'h20, 4'h7, 1'b0);
    id_mem_r = 1'b1;
    step();
    chk("pre_frz_pc", ex_pc, 32'h20);
    freeze = 1'b1; id_pc = 32'h99; cond_pass = 1'b0; id_dest = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc", ex_pc, 32'h20);
      chk("frz_ctrl", {ex_valid, ex_mem_r, ex_dest}, {1'b1, 1'b1, 4'h7});
      chk("frz_cnt", squash_cnt, 1);
    end

    // Flush beats freeze
    flush = 1'b1;
    step();
    chk("fl_valid", ex_valid, 0);
    chk("fl_pc", ex_pc, 0);
    chk("fl_ctrl", {ex_mem_r, ex_dest}, 0);
    chk("fl_cnt", squash_cnt, 1);

    // Status commit: S instruction enters EXE
    flush = 1'b0; freeze = 1'b0;
    liveInstr(32'h30, 4'h2, 1'b1);
    step();
    chk("s_in_ex", {ex_valid, ex_s}, 2'b11);
`ifdef SR_BYPASS_EN
    chk("sr_bypass", sr_nzcv, 4'b0110);
`else
    chk("sr_not_yet", sr_nzcv, 0);
`endif
    freeze = 1'b1;
    step();
    chk("sr_frozen", sr_nzcv, 0);
    freeze = 1'b0;
    liveInstr(32'h34, 4'h2, 1'b0);
    step();
    chk("sr_commit", sr_nzcv, 4'b0110);

    // Commit still happens in the flush cycle
    liveInstr(32'h38, 4'h2, 1'b1);
    alu_nzcv = 4'b1001;
    step();
    flush = 1'b1;
    step();
    chk("sr_flush", sr_nzcv, 4'b1001);
    chk("sr_flush_v", ex_valid, 0);

    // Bubble with S set never writes flags
    flush = 1'b0; hazard = 1'b1; id_s = 1'b1;
    step();
    chk("bub_s", {ex_valid, ex_s}, 0);
    alu_nzcv = 4'b1111;
    step();
    chk("bub_sr", sr_nzcv, 4'b1001);

    // Reset mid-stream
    liveInstr(32'h40, 4'h4, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("mrst_sr", sr_nzcv, 0);
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_cnt", squash_cnt, 0);
    rst = 1'b0;

    // Saturation of squash counter
    id_valid = 1'b1; hazard = 1'b0; cond_pass = 1'b0; id_s = 1'b0;
    repeat (65533) @(posedge clk);
    step();
    chk("sat_m1", squash_cnt, 16'hFFFE);
    step();
    chk("sat_full", squash_cnt, 16'hFFFF);
    step();
    step();
    chk("sat_hold", squash_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

- Pipeline register between the ID stage and the EXE stage. It latches the decoded instruction each cycle.
- It converts an instruction into a bubble when the instruction's condition fails or a hazard is flagged.
- It owns the NZCV status register: updated from the EXE-stage ALU, fed back to the ID-stage condition checker.
- It keeps a saturating count of condition-failed (squashed) instructions.

## Interface

Parameters:
- `SQ_CNT_W`, 16: width of the squash counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hold every register (memory stall).
- `flush` in 1: branch taken in EXE; clear this stage.
- `hazard` in 1: ID-stage hazard; insert bubble.
- `cond_pass` in 1: condition-check result for the ID instruction.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_val_rn` in 32: Rn read value.
- `id_val_rm` in 32: Rm read value.
- `id_shift_op` in 12: shifter operand field.
- `id_imm` in 1: immediate flag.
- `id_simm24` in 24: branch offset.
- `id_dest`, `id_src1`, `id_src2` in 4 each: register numbers.
- `id_exe_cmd` in 4: ALU command.
- `id_mem_r`, `id_mem_w`, `id_wb_en`, `id_s`, `id_b` in 1 each: control bits.
- `alu_nzcv` in 4: flags produced by the EXE ALU, {N,Z,C,V}.
- `ex_*` out: registered copies of every `id_*` field, plus `ex_valid` out 1.
- `sr_nzcv` out 4: status register value {N,Z,C,V}, fed to the condition checker.
- `squash_cnt` out `SQ_CNT_W`: count of condition-failed instructions.

## Operation

**Stage register: one rule per rising edge, in priority order.**
- `rst`: all `ex_*` outputs, `ex_valid`, `sr_nzcv` and `squash_cnt` go to 0.
- `flush`: `ex_valid` and all control bits (`mem_r`, `mem_w`, `wb_en`, `s`, `b`) go to 0. Datapath fields go to 0. Overrides `freeze`.
- `freeze`: every register holds its value.
- Otherwise, load all data fields from `id_*`.
  - Bubble when `hazard | ~cond_pass | ~id_valid`: `ex_valid` and the five control bits load 0; `ex_exe_cmd` loads 0.
  - Live instruction otherwise: controls load from `id_*` and `ex_valid` is 1.

**Status register**
- Commit condition: `ex_valid & ex_s & ~freeze`. When it holds, `sr_nzcv <= alu_nzcv`.
- `flush` does not block the commit: the branch in EXE still retires.
- A bubble never writes the status register.

**Squash counter**
- Increments on a load cycle (no `rst`, `flush` or `freeze`) when `id_valid & ~hazard & ~cond_pass`.
- Hazard bubbles are not counted.
- Saturates at all-ones and never wraps.

## Timing

- Latency: exactly 1 cycle from ID inputs to `ex_*`. No combinational path from inputs to outputs, except `sr_nzcv` as described under Configuration.
- `sr_nzcv` changes at the edge that commits the instruction, so the ID instruction in the next cycle sees the new flags.
- Status register, same cycle as `flush`: `sr_nzcv` still commits. The stage register clears.
- Status register, same cycle as `freeze`: no commit. The instruction commits on the first unfrozen edge.
- Squash counter at saturation: it stays at 0xFFFF (default width).
- Reset mid-stream: one edge of `rst` clears the pipeline and the status register. The first instruction after reset sees NZCV = 0000.

## Configuration

- `SR_BYPASS_EN` defined:
  - `sr_nzcv` is driven combinationally: `alu_nzcv` when the commit condition holds in the current cycle, else the registered value.
  - The ID instruction behind a flag-setting instruction then evaluates with fresh flags, with no stall.
- `SR_BYPASS_EN` undefined:
  - `sr_nzcv` is the registered value only.
  - The hazard unit must stall one cycle behind `S=1` instructions.

## Test plan

- **Reset:** assert `rst` with all inputs non-zero for 1 cycle -> all outputs 0 next cycle; `squash_cnt` = 0.
- **Normal load:** `id_valid`=1, `cond_pass`=1, `id_wb_en`=1, `id_dest`=4'h3, `id_pc`=32'h10 -> next cycle `ex_valid`=1, `ex_wb_en`=1, `ex_dest`=3, `ex_pc`=32'h10.
- **Condition squash:** `cond_pass`=0 with `id_mem_w`=1 -> `ex_valid`=0, `ex_mem_w`=0, `squash_cnt` increments by 1. Repeat with `hazard`=1 -> bubble, counter unchanged.
- **Flush beats freeze:** assert `flush`=1 and `freeze`=1 together with a live EXE instruction -> `ex_valid`=0 next cycle.
- **Freeze hold:** `freeze`=1 for 3 cycles -> all `ex_*` outputs unchanged.
- **Status commit:**
  - Setup: EXE holds `ex_s`=1, `ex_valid`=1, `alu_nzcv`=4'b0110.
  - Not frozen -> `sr_nzcv`=0110 after the edge.
  - With `SR_BYPASS_EN` -> `sr_nzcv`=0110 in the same cycle.
  - With `freeze`=1 -> no change until released.
- **Saturation:** force 65,536 condition squashes -> `squash_cnt` holds at 16'hFFFF.
